// File: rtl/approx_sum_error_monitor.sv
// Error-statistics monitor for an N-bit approximate adder: exact-sum reference, 2-stage ED pipeline.
// Optional macro ERR_SQ_EN adds a saturating sum of squared error distances (sum_sq_ed).
module approx_sum_error_monitor #(
  parameter int N     = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [N-1:0]     max_ed,
  output logic [ACC_W-1:0] sum_ed
`ifdef ERR_SQ_EN
  ,
  output logic [ACC_W-1:0] sum_sq_ed
`endif
);

  localparam int SAT_W = ((ACC_W > 2 * N) ? ACC_W : 2 * N) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic logic [N-1:0] abs_diff(input logic [N-1:0] x, input logic [N-1:0] y);
    logic signed [N:0] d;
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    return d[N] ? N'(-d) : N'(d);
  endfunction

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [2*N-1:0] inc);
    logic [SAT_W-1:0] s;
    s = SAT_W'(acc) + SAT_W'(inc);
    return (s > SAT_W'(ACC_MAX)) ? ACC_MAX : s[ACC_W-1:0];
  endfunction

  state_t           state;
  logic [CNT_W-1:0] n_lat;
  logic             hs;
  logic             last_hs;
  logic [N-1:0]     exact_p0;
  logic [N-1:0]     exact_p1;
  logic [N-1:0]     approx_p1;
  logic             vld_p1;
  logic [N-1:0]     ed_p1;
  logic [2*N-1:0]   ed_w_p1;

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign hs       = in_valid & in_ready;
  assign last_hs  = hs && (sample_count == n_lat - CNT_W'(1));
  assign exact_p0 = a + b;

  // Stage 1: register reference sum and adder output
  always_ff @(posedge clk) begin
    if (hs) begin
      exact_p1  <= exact_p0;
      approx_p1 <= approx_sum;
    end
  end

  // Stage 2: error distance and statistics update
  assign ed_p1   = abs_diff(exact_p1, approx_p1);
  assign ed_w_p1 = (2 * N)'(ed_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      n_lat        <= '0;
      sample_count <= '0;
      err_count    <= '0;
      max_ed       <= '0;
      sum_ed       <= '0;
      vld_p1       <= 1'b0;
`ifdef ERR_SQ_EN
      sum_sq_ed    <= '0;
`endif
    end else begin
      vld_p1 <= hs;
      if (vld_p1) begin
        if (ed_p1 != '0) err_count <= err_count + CNT_W'(1);
        if (ed_p1 > max_ed) max_ed <= ed_p1;
        sum_ed <= sat_add(sum_ed, ed_w_p1);
`ifdef ERR_SQ_EN
        sum_sq_ed <= sat_add(sum_sq_ed, ed_w_p1 * ed_w_p1);
`endif
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            n_lat        <= num_samples;
            sample_count <= '0;
            err_count    <= '0;
            max_ed       <= '0;
            sum_ed       <= '0;
`ifdef ERR_SQ_EN
            sum_sq_ed    <= '0;
`endif
            state        <= (num_samples != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (hs) begin
            sample_count <= sample_count + CNT_W'(1);
            if (last_hs) state <= DRAIN;
          end
        end
        // Nothing enters stage 1 here, so the last sample commits on this same edge.
        DRAIN:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_sum_error_monitor.sv
// Randomized self-checking bench for approx_sum_error_monitor with a queue-free array reference model.
// Define ERR_SQ_EN to also exercise sum_sq_ed.
module tb_approx_sum_error_monitor;

  localparam int N     = 8;
  localparam int CNT_W = 16;
  localparam int ACC_W = 10;
  localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     a = '0;
  logic [N-1:0]     b = '0;
  logic [N-1:0]     approx_sum = '0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W-1:0] err_count;
  logic [N-1:0]     max_ed;
  logic [ACC_W-1:0] sum_ed;
`ifdef ERR_SQ_EN
  logic [ACC_W-1:0] sum_sq_ed;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] sa [256];
  logic [N-1:0] sb [256];
  logic [N-1:0] sx [256];

  approx_sum_error_monitor #(.N(N), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .approx_sum(approx_sum),
    .busy(busy), .done(done), .sample_count(sample_count), .err_count(err_count),
    .max_ed(max_ed), .sum_ed(sum_ed)
`ifdef ERR_SQ_EN
    , .sum_sq_ed(sum_sq_ed)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: statistics of the first n table entries, straight from the definitions.
  task automatic model_stats(input int n, output longint e_cnt, output longint e_max,
                             output longint e_sum, output longint e_sq);
    longint ex, ed;
    e_cnt = 0; e_max = 0; e_sum = 0; e_sq = 0;
    for (int i = 0; i < n; i++) begin
      ex = (longint'(sa[i]) + longint'(sb[i])) % 256;
      ed = (ex > longint'(sx[i])) ? ex - longint'(sx[i]) : longint'(sx[i]) - ex;
      if (ed != 0) e_cnt++;
      if (ed > e_max) e_max = ed;
      e_sum = (e_sum + ed > ACC_MAX) ? ACC_MAX : e_sum + ed;
      e_sq  = (e_sq + ed * ed > ACC_MAX) ? ACC_MAX : e_sq + ed * ed;
    end
  endtask

  task automatic fill_random(input int n);
    int ex;
    for (int i = 0; i < n; i++) begin
      sa[i] = N'($urandom);
      sb[i] = N'($urandom);
      ex = (int'(sa[i]) + int'(sb[i])) % 256;
      case ($urandom_range(0, 3))
        0:       sx[i] = N'(ex);
        1:       sx[i] = N'(ex) ^ N'(1 << $urandom_range(0, 7));
        2:       sx[i] = N'($urandom);
        default: sx[i] = N'(ex) ^ N'($urandom_range(0, 7));
      endcase
    end
  endtask

  task automatic check_stats(input string tag, input int n);
    longint e_cnt, e_max, e_sum, e_sq;
    model_stats(n, e_cnt, e_max, e_sum, e_sq);
    check_eq({tag, "_err"}, 64'(err_count), 64'(e_cnt));
    check_eq({tag, "_max"}, 64'(max_ed), 64'(e_max));
    check_eq({tag, "_sum"}, 64'(sum_ed), 64'(e_sum));
`ifdef ERR_SQ_EN
    check_eq({tag, "_sq"}, 64'(sum_sq_ed), 64'(e_sq));
`endif
  endtask

  task automatic run_window(input string tag, input int n, input int vprob, input bit poke_start);
    int acc, cyc;
    bit poked;
    @(negedge clk);
    start = 1'b1; num_samples = CNT_W'(n); in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_stats({tag, "_clr"}, 0);
    check_eq({tag, "_cnt0"}, 64'(sample_count), 0);
    if (n == 0) begin
      check_eq({tag, "_done0"}, 64'(done), 1);
      check_eq({tag, "_busy0"}, 64'(busy), 0);
      check_eq({tag, "_rdy0"}, 64'(in_ready), 0);
      @(negedge clk);
      check_eq({tag, "_hold0"}, 64'(done), 1);
      return;
    end
    check_eq({tag, "_busy"}, 64'(busy), 1);
    check_eq({tag, "_done"}, 64'(done), 0);
    acc = 0; cyc = 0; poked = 1'b0;
    while (acc < n && cyc < 4000) begin
      check_eq({tag, "_rdy"}, 64'(in_ready), 1);
      check_eq({tag, "_cnt"}, 64'(sample_count), 64'(acc));
      if (poke_start && !poked && acc >= n / 2) begin
        start = 1'b1; num_samples = '0; poked = 1'b1;
      end
      in_valid = ($urandom_range(0, 99) < vprob);
      a = sa[acc]; b = sb[acc]; approx_sum = sx[acc];
      @(posedge clk);
      if (in_valid) acc++;
      cyc++;
      @(negedge clk);
      start = 1'b0; num_samples = CNT_W'(n);
    end
    check_eq({tag, "_timeout"}, 64'(acc), 64'(n));
    // One cycle after the final handshake: still draining, extra samples refused.
    in_valid = 1'b1; a = N'($urandom); b = N'($urandom); approx_sum = N'($urandom);
    check_eq({tag, "_drn_done"}, 64'(done), 0);
    check_eq({tag, "_drn_busy"}, 64'(busy), 1);
    check_eq({tag, "_drn_rdy"}, 64'(in_ready), 0);
    @(negedge clk);
    check_eq({tag, "_fin_done"}, 64'(done), 1);
    check_eq({tag, "_fin_busy"}, 64'(busy), 0);
    check_eq({tag, "_fin_rdy"}, 64'(in_ready), 0);
    check_eq({tag, "_fin_cnt"}, 64'(sample_count), 64'(n));
    check_stats({tag, "_fin"}, n);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq({tag, "_post_cnt"}, 64'(sample_count), 64'(n));
    check_eq({tag, "_post_done"}, 64'(done), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rdy"}, 64'(in_ready), 0);
    check_eq({tag, "_busy"}, 64'(busy), 0);
    check_eq({tag, "_done"}, 64'(done), 0);
    check_eq({tag, "_cnt"}, 64'(sample_count), 0);
    check_eq({tag, "_err"}, 64'(err_count), 0);
    check_eq({tag, "_max"}, 64'(max_ed), 0);
    check_eq({tag, "_sum"}, 64'(sum_ed), 0);
`ifdef ERR_SQ_EN
    check_eq({tag, "_sq"}, 64'(sum_sq_ed), 0);
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;

    // Valid offered while idle is never consumed
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_rdy", 64'(in_ready), 0);
    check_eq("idle_cnt", 64'(sample_count), 0);
    in_valid = 1'b0;

    sa[0] = 8'h0F; sb[0] = 8'h01; sx[0] = 8'h10;
    run_window("single", 1, 100, 1'b0);
    check_eq("single_err_k", 64'(err_count), 0);

    sa[0] = 8'h0F; sb[0] = 8'h01; sx[0] = 8'h0E;
    sa[1] = 8'h80; sb[1] = 8'h80; sx[1] = 8'h00;
    sa[2] = 8'h10; sb[2] = 8'h20; sx[2] = 8'h38;
    run_window("three", 3, 60, 1'b0);
    check_eq("three_err_k", 64'(err_count), 2);
    check_eq("three_max_k", 64'(max_ed), 8);
    check_eq("three_sum_k", 64'(sum_ed), 10);
    check_eq("three_cnt_k", 64'(sample_count), 3);

    fill_random(2);
    run_window("hold", 2, 100, 1'b0);

    run_window("zero", 0, 100, 1'b0);

    fill_random(12);
    run_window("poke", 12, 80, 1'b1);

    for (int w = 0; w < 8; w++) begin
      int n;
      n = $urandom_range(1, 24);
      fill_random(n);
      run_window("rand", n, $urandom_range(30, 100), (w % 2) == 1);
    end

    for (int i = 0; i < 80; i++) begin
      sa[i] = N'($urandom_range(16, 255));
      sb[i] = '0;
      sx[i] = sa[i] - 8'h10;
    end
    run_window("sat", 80, 90, 1'b0);
    check_eq("sat_sum_k", 64'(sum_ed), 64'(ACC_MAX));

    // Asynchronous reset in the middle of a window
    fill_random(10);
    @(negedge clk);
    start = 1'b1; num_samples = 16'd10;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = sa[i]; b = sb[i]; approx_sum = sx[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("midrst_rel");

    fill_random(5);
    run_window("after", 5, 70, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
